filterbank_scheduler: RTL and testbench
=======================================

# filterbank_scheduler

Sequences the vocoder's shared biquad engine across all filter channels and processing stages for each new audio sample. Every `valid_in` strobe starts a frame of `N_FILTERS × 3` jobs, issued one at a time in modulator → envelope → carrier order per channel, over a valid/ready + done handshake. It sits between the sample source (mic / line-in mux) and the shared filter engine, and feeds the mixer's `valid_in` with a frame-complete pulse. It also buffers one early sample, flags overruns and engine timeouts, and handles source-change flushes.

## Interface
- `N_FILTERS`, default 16: channels per frame; power of two, ≥ 2.
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the engine is declared hung.
- `clk_in` in 1: single clock (the filterbank clock).
- `rst_in` in 1: reset, asynchronous, active-high.
- `valid_in` in 1: one-cycle strobe, a new sample pair is ready.
- `flush_in` in 1: synchronous abort/restart on source change.
- `job_valid_out` out 1: a job is offered to the engine.
- `job_ready_in` in 1: the engine accepts the job.
- `job_channel_out` out `$clog2(N_FILTERS)`: channel index of the current job.
- `job_stage_out` out 2: stage of the current job, type `stage_t`.
- `job_coef_addr_out` out `$clog2(N_FILTERS)+2`: coefficient address, `{channel, stage}`.
- `done_in` in 1: one-cycle pulse, the engine finished the accepted job.
- `frame_valid_out` out 1: one-cycle pulse, all jobs of the frame are complete.
- `state_clr_out` out 1: one-cycle pulse telling the engine to zero its filter state.
- `busy_out` out 1: high whenever the FSM is not in IDLE.
- `overrun_out` out 1: sticky flag, a sample was dropped.
- `fault_out` out 1: sticky flag, an engine timeout occurred.

## Operation
- FSM states:
  - IDLE → ISSUE when `valid_in` is high or `pending` is set (consumes `pending`); channel and stage are zeroed.
  - ISSUE drives `job_valid_out` = 1 → WAIT on `job_ready_in`.
  - WAIT → ISSUE on `done_in`, after advancing. Advance order: stage MOD(0) → ENV(1) → CAR(2); after CAR the stage returns to MOD and channel increments.
  - WAIT → DONE on `done_in` when channel = `N_FILTERS`-1 and stage = CAR.
  - DONE drives `frame_valid_out` = 1 → ISSUE if `pending` or `valid_in` is high (starts a new frame at ch0/MOD), otherwise → IDLE.
- `stage_t` encoding is 0/1/2; the value 3 is never driven.
- One-deep sample buffer:
  - `valid_in` outside IDLE with `pending` = 0 sets `pending`.
  - `valid_in` outside IDLE with `pending` = 1 sets `overrun_out`; the sample is dropped and `pending` stays set.
  - `valid_in` in DONE is consumed directly and does not set `pending`.
- Watchdog:
  - Counter clears on entry to WAIT and increments every WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` without `done_in` sets `fault_out` → IDLE.
  - No `frame_valid_out` for the aborted frame; `pending` is kept and is served from IDLE.
- `done_in` outside WAIT is ignored. `job_ready_in` outside ISSUE is ignored.
- `flush_in` has priority over all other events:
  - Next state is IDLE; `pending`, channel, stage and the watchdog counter clear.
  - `state_clr_out` pulses the following cycle.
  - Sticky flags are unaffected.
  - `valid_in` in the same cycle as `flush_in` is dropped without setting `overrun_out`.
- The sticky flags clear only on `rst_in`.

## Timing
- Reset values: all outputs 0; FSM IDLE; `pending` 0; counters 0.
- `valid_in` in IDLE at cycle 0 → `job_valid_out` high at cycle 1.
- `job_*` outputs are registered and stable while `job_valid_out` is high. Acceptance happens in the cycle where `job_valid_out` and `job_ready_in` are both high; `job_valid_out` is low the next cycle.
- `done_in` at cycle t → next job offered at t+1 (one bubble cycle per job).
- Final `done_in` at t → `frame_valid_out` at t+1 → IDLE or ISSUE at t+2.
- Minimum frame length with zero-wait engine: `3·N_FILTERS·(ISSUE + WAIT + done latency)` plus 2 cycles.
- `busy_out` is combinational from the state register, so there is no extra latency.
- Asynchronous reset mid-frame: outputs clear immediately and no `frame_valid_out` is emitted.

## Structure
- `constants` package: add `stage_t` (`STAGE_MOD` = 0, `STAGE_ENV` = 1, `STAGE_CAR` = 2) and `SCHED_TIMEOUT_CYCLES`. `N_FILTERS` already lives there.
- FSM state enum stays local to the module.
- Single module; there is no natural sub-module. The watchdog is a counter inline in the module.

## Test plan
- Single frame, `N_FILTERS` = 4, engine with ready always 1 and `done_in` 2 cycles after accept → 12 jobs in order ch0 MOD/ENV/CAR … ch3 CAR; `job_coef_addr_out` runs 0,1,2,4,5,6,…,14; exactly one `frame_valid_out`.
- `valid_in` mid-frame → `pending` set; the second frame starts the cycle after `frame_valid_out` with no IDLE cycle; `overrun_out` stays 0.
- Three `valid_in` pulses within one frame → `overrun_out` = 1; exactly 2 frames complete.
- Engine never asserts `done_in`, `TIMEOUT_CYCLES` = 8 → `fault_out` rises 8 cycles after accept; FSM returns to IDLE; no `frame_valid_out`.
- `flush_in` during WAIT of ch2 ENV → `state_clr_out` pulses at +1; `busy_out` = 0 at +1; a late `done_in` is ignored; the next `valid_in` restarts at ch0 MOD.
- `rst_in` asserted asynchronously mid-frame → all outputs 0 before the next edge; sticky flags cleared.

Source files
------------

// File: rtl/filterbank_scheduler_pkg.sv
// filterbank_scheduler_pkg: shared vocoder filterbank constants and the biquad stage type
package filterbank_scheduler_pkg;
   localparam int N_FILTERS            = 16;
   localparam int SCHED_TIMEOUT_CYCLES = 64;
   typedef enum logic [1:0] {
      STAGE_MOD = 2'd0,
      STAGE_ENV = 2'd1,
      STAGE_CAR = 2'd2
   } stage_t;
endpackage

// File: rtl/filterbank_scheduler.sv
// filterbank_scheduler: issues N_FILTERS x 3 biquad jobs per sample to the shared engine
// Ports: clk_in/rst_in (async high); valid_in sample strobe; flush_in source-change abort;
//        job_valid_out/job_ready_in/job_channel_out/job_stage_out/job_coef_addr_out job offer;
//        done_in job complete; frame_valid_out frame pulse; state_clr_out engine state clear;
//        busy_out not idle; overrun_out/fault_out sticky dropped-sample / engine-timeout flags
module filterbank_scheduler #(
   parameter int N_FILTERS      = filterbank_scheduler_pkg::N_FILTERS,
   parameter int TIMEOUT_CYCLES = filterbank_scheduler_pkg::SCHED_TIMEOUT_CYCLES
) (
   input  logic                                clk_in,
   input  logic                                rst_in,
   input  logic                                valid_in,
   input  logic                                flush_in,
   output logic                                job_valid_out,
   input  logic                                job_ready_in,
   output logic [$clog2(N_FILTERS)-1:0]        job_channel_out,
   output filterbank_scheduler_pkg::stage_t    job_stage_out,
   output logic [$clog2(N_FILTERS)+1:0]        job_coef_addr_out,
   input  logic                                done_in,
   output logic                                frame_valid_out,
   output logic                                state_clr_out,
   output logic                                busy_out,
   output logic                                overrun_out,
   output logic                                fault_out
);
   import filterbank_scheduler_pkg::*;
   localparam int CW = $clog2(N_FILTERS);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
   state_t         state, state_n;
   logic [CW-1:0]  ch, ch_n;
   stage_t         stg, stg_n;
   logic [TW-1:0]  cnt, cnt_n;
   logic           pending, pending_n, overrun_n, fault_n, last;
   assign last = (ch == CW'(N_FILTERS - 1)) && (stg == STAGE_CAR);
   always_comb begin
      state_n   = state;
      ch_n      = ch;
      stg_n     = stg;
      cnt_n     = cnt;
      pending_n = pending;
      overrun_n = overrun_out;
      fault_n   = fault_out;
      unique case (state)
         S_IDLE: if (valid_in || pending) begin
            state_n   = S_ISSUE;
            ch_n      = '0;
            stg_n     = STAGE_MOD;
            // a buffered sample is served first; a coincident strobe takes its place
            pending_n = pending && valid_in;
         end
         S_ISSUE: if (job_ready_in) begin
            state_n = S_WAIT;
            cnt_n   = '0;
         end
         S_WAIT: if (done_in) begin
            state_n = last ? S_DONE : S_ISSUE;
            stg_n   = (stg == STAGE_CAR) ? STAGE_MOD : stage_t'(stg + 2'd1);
            ch_n    = (stg == STAGE_CAR) ? ch + CW'(1) : ch;
         end else if (cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            // engine hung: abandon the frame, keep any buffered sample for IDLE
            state_n = S_IDLE;
            fault_n = 1'b1;
         end else begin
            cnt_n = cnt + TW'(1);
         end
         S_DONE: begin
            state_n   = (pending || valid_in) ? S_ISSUE : S_IDLE;
            ch_n      = '0;
            stg_n     = STAGE_MOD;
            pending_n = pending && valid_in;
         end
      endcase
      if (valid_in && (state == S_ISSUE || state == S_WAIT)) begin
         overrun_n = overrun_out | pending;
         pending_n = 1'b1;
      end
      if (flush_in) begin
         state_n   = S_IDLE;
         ch_n      = '0;
         stg_n     = STAGE_MOD;
         cnt_n     = '0;
         pending_n = 1'b0;
         overrun_n = overrun_out;
         fault_n   = fault_out;
      end
   end
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state         <= S_IDLE;
         ch            <= '0;
         stg           <= STAGE_MOD;
         cnt           <= '0;
         pending       <= 1'b0;
         overrun_out   <= 1'b0;
         fault_out     <= 1'b0;
         state_clr_out <= 1'b0;
      end else begin
         state         <= state_n;
         ch            <= ch_n;
         stg           <= stg_n;
         cnt           <= cnt_n;
         pending       <= pending_n;
         overrun_out   <= overrun_n;
         fault_out     <= fault_n;
         state_clr_out <= flush_in;
      end
   end
   assign job_valid_out     = state == S_ISSUE;
   assign frame_valid_out   = state == S_DONE;
   assign busy_out          = state != S_IDLE;
   assign job_channel_out   = ch;
   assign job_stage_out     = stg;
   assign job_coef_addr_out = {ch, stg};
endmodule

// File: tb/tb_filterbank_scheduler.sv
// tb_filterbank_scheduler: directed checks of job order, buffering, overrun, timeout, flush, reset
module tb_filterbank_scheduler;
   logic clk_in = 1'b0, rst_in = 1'b1, valid_in = 1'b0, flush_in = 1'b0;
   logic job_ready_in = 1'b0, done_in = 1'b0;
   logic job_valid_out, frame_valid_out, state_clr_out, busy_out, overrun_out, fault_out;
   logic [1:0] job_channel_out;
   filterbank_scheduler_pkg::stage_t job_stage_out;
   logic [3:0] job_coef_addr_out;
   int tests = 0, fails = 0, fv = 0, f0 = 0;
   filterbank_scheduler #(.N_FILTERS(4), .TIMEOUT_CYCLES(8)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .flush_in(flush_in),
      .job_valid_out(job_valid_out), .job_ready_in(job_ready_in),
      .job_channel_out(job_channel_out), .job_stage_out(job_stage_out),
      .job_coef_addr_out(job_coef_addr_out), .done_in(done_in),
      .frame_valid_out(frame_valid_out), .state_clr_out(state_clr_out),
      .busy_out(busy_out), .overrun_out(overrun_out), .fault_out(fault_out)
   );
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) if (frame_valid_out) fv++;
   task automatic tick;
      @(posedge clk_in);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   // job k is channel k/3, stage k%3; a valid_in pulse is injected in the WAIT of jobs vp1/vp2
   task automatic run_jobs(input int n, input int vp1, input int vp2);
      for (int k = 0; k < n; k++) begin
         int w = 0;
         while (!job_valid_out && w < 20) begin
            tick;
            w++;
         end
         chk("job_valid", job_valid_out, 1);
         chk("job_channel", job_channel_out, k / 3);
         chk("job_stage", job_stage_out, k % 3);
         chk("job_coef", job_coef_addr_out, (k / 3) * 4 + k % 3);
         job_ready_in = 1'b1;
         tick;
         job_ready_in = 1'b0;
         chk("job_valid_drop", job_valid_out, 0);
         valid_in = (k == vp1 || k == vp2);
         tick;
         valid_in = 1'b0;
         done_in = 1'b1;
         tick;
         done_in = 1'b0;
      end
   endtask
   initial begin
      tick;
      tick;
      chk("rst_job_valid", job_valid_out, 0);
      chk("rst_busy", busy_out, 0);
      chk("rst_frame_valid", frame_valid_out, 0);
      chk("rst_state_clr", state_clr_out, 0);
      chk("rst_overrun", overrun_out, 0);
      chk("rst_fault", fault_out, 0);
      chk("rst_coef", job_coef_addr_out, 0);
      rst_in = 1'b0;
      tick;
      // single frame
      f0 = fv;
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      chk("start_latency", job_valid_out, 1);
      chk("start_busy", busy_out, 1);
      run_jobs(12, -1, -1);
      chk("f1_frame_valid", frame_valid_out, 1);
      chk("f1_busy_done", busy_out, 1);
      tick;
      chk("f1_frame_pulse", frame_valid_out, 0);
      chk("f1_idle", busy_out, 0);
      chk("f1_count", fv - f0, 1);
      // mid-frame sample buffered, next frame back-to-back
      f0 = fv;
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      run_jobs(12, 4, -1);
      chk("f2_frame_valid", frame_valid_out, 1);
      chk("f2_no_overrun", overrun_out, 0);
      tick;
      chk("f3_back2back", job_valid_out, 1);
      chk("f3_busy", busy_out, 1);
      run_jobs(12, -1, -1);
      chk("f3_frame_valid", frame_valid_out, 1);
      tick;
      chk("f3_idle", busy_out, 0);
      chk("f23_count", fv - f0, 2);
      chk("f3_no_overrun", overrun_out, 0);
      // three samples in one frame
      f0 = fv;
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      run_jobs(12, 1, 8);
      chk("ovr_flag", overrun_out, 1);
      chk("ovr_frame_valid", frame_valid_out, 1);
      tick;
      chk("ovr_second_start", job_valid_out, 1);
      run_jobs(12, -1, -1);
      chk("ovr_frame2_valid", frame_valid_out, 1);
      tick;
      tick;
      chk("ovr_idle", busy_out, 0);
      chk("ovr_count", fv - f0, 2);
      // engine hang with a buffered sample
      f0 = fv;
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      chk("to_offer", job_valid_out, 1);
      job_ready_in = 1'b1;
      tick;
      job_ready_in = 1'b0;
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      repeat (6) tick;
      chk("to_before_fault", fault_out, 0);
      chk("to_still_wait", busy_out, 1);
      tick;
      chk("to_fault", fault_out, 1);
      chk("to_idle", busy_out, 0);
      chk("to_no_frame", frame_valid_out, 0);
      tick;
      chk("to_pending_served", job_valid_out, 1);
      chk("to_restart_ch", job_channel_out, 0);
      chk("to_restart_stage", job_stage_out, 0);
      chk("to_count", fv - f0, 0);
      // flush during WAIT of ch2 ENV
      run_jobs(7, -1, -1);
      chk("fl_coef", job_coef_addr_out, 9);
      job_ready_in = 1'b1;
      tick;
      job_ready_in = 1'b0;
      flush_in = 1'b1;
      tick;
      flush_in = 1'b0;
      chk("fl_state_clr", state_clr_out, 1);
      chk("fl_busy", busy_out, 0);
      chk("fl_job_valid", job_valid_out, 0);
      chk("fl_fault_sticky", fault_out, 1);
      done_in = 1'b1;
      tick;
      done_in = 1'b0;
      chk("fl_clr_pulse", state_clr_out, 0);
      chk("fl_late_done", busy_out, 0);
      valid_in = 1'b1;
      tick;
      valid_in = 1'b0;
      chk("fl_restart", job_valid_out, 1);
      chk("fl_restart_coef", job_coef_addr_out, 0);
      chk("fl_count", fv - f0, 0);
      // asynchronous reset mid-frame
      run_jobs(1, -1, -1);
      chk("ar_pre_valid", job_valid_out, 1);
      chk("ar_pre_coef", job_coef_addr_out, 1);
      f0 = fv;
      #2 rst_in = 1'b1;
      #1;
      chk("ar_job_valid", job_valid_out, 0);
      chk("ar_busy", busy_out, 0);
      chk("ar_coef", job_coef_addr_out, 0);
      chk("ar_overrun", overrun_out, 0);
      chk("ar_fault", fault_out, 0);
      chk("ar_state_clr", state_clr_out, 0);
      tick;
      rst_in = 1'b0;
      tick;
      tick;
      chk("ar_idle", busy_out, 0);
      chk("ar_count", fv - f0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
